dma_cfg_slave: RTL

AXI slave register block that sits directly upstream of the DMA master engine. The CPU uses it to program source address, destination address and word quantity. It issues a one-cycle start pulse to the engine and collects the engine's finish pulse into a status bit and an interrupt line. Fully synchronous single-clock design; all register updates and response signals are registered.

---
 rtl/dma_cfg_slave.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_cfg_slave.sv
// AXI register slave in front of the DMA engine: holds source/destination/quantity
// configuration, issues the start pulse and turns the finish pulse into status/irq.
module dma_cfg_slave #(
    parameter int IDW    = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDW-1:0]      awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [IDW-1:0]      bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [IDW-1:0]      arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [LEN_W-1:0]    arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [IDW-1:0]      rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic                dma_en_o,
    output logic [DATA_W-1:0]   src_addr_o,
    output logic [DATA_W-1:0]   dst_addr_o,
    output logic [DATA_W-1:0]   data_qty_o,
    input  logic                dma_fin_i,
    output logic                irq_o
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [11:0] OFF_SRC    = 12'h000;
    localparam logic [11:0] OFF_DST    = 12'h004;
    localparam logic [11:0] OFF_QTY    = 12'h008;
    localparam logic [11:0] OFF_CTRL   = 12'h00C;
    localparam logic [11:0] OFF_STATUS = 12'h010;
    localparam logic [11:0] OFF_IE     = 12'h014;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, BRESP, RDATA} state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]    id_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic              fixed_q, err_q;
    logic [DATA_W-1:0] src_q, dst_q, qty_q, rdata_q;
    logic [1:0]        rresp_q;
    logic              busy_q, done_q, ie_q, dma_en_q;

    logic              aw_hs, ar_hs, w_hs, b_hs, r_hs, last_beat;
    logic [11:0]       w_off, rd_off;
    logic              w_mapped, wr_cfg, start, clr_done, ie_wr;
    logic [DATA_W:0]   rd_word;   // {unmapped, data}

    // Transfer sizes are not used: every beat is one full register.
    logic unused_size;
    assign unused_size = ^{awsize, arsize};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] nw,
                                                      input logic [STRB_W-1:0] strb);
        merge_bytes = cur;
        for (int i = 0; i < STRB_W; i++)
            if (strb[i]) merge_bytes[8*i +: 8] = nw[8*i +: 8];
    endfunction

    assign aw_hs     = (state_q == IDLE)  && awvalid;
    assign ar_hs     = (state_q == IDLE)  && arvalid && !awvalid;
    assign w_hs      = (state_q == WDATA) && wvalid;
    assign b_hs      = (state_q == BRESP) && bready;
    assign r_hs      = (state_q == RDATA) && rready;
    assign last_beat = (cnt_q == len_q);
    assign addr_nxt  = fixed_q ? addr_q : addr_q + ADDR_W'(4);

    assign w_off    = addr_q[11:0];
    assign w_mapped = w_off inside {OFF_SRC, OFF_DST, OFF_QTY, OFF_CTRL, OFF_STATUS, OFF_IE};
    assign wr_cfg   = w_hs && !busy_q;
    assign start    = wr_cfg && (w_off == OFF_CTRL) && wstrb[0] && wdata[0];
    assign clr_done = w_hs && (w_off == OFF_STATUS) && wstrb[0] && wdata[1];
    assign ie_wr    = w_hs && (w_off == OFF_IE) && wstrb[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output is defaulted before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                awready = 1'b1;
                arready = !awvalid;
                if (aw_hs)      state_d = WDATA;
                else if (ar_hs) state_d = RDATA;
            end
            WDATA: begin
                wready = 1'b1;
                if (w_hs && (wlast || last_beat)) state_d = BRESP;
            end
            BRESP: begin
                bvalid = 1'b1;
                if (b_hs) state_d = IDLE;
            end
            RDATA: begin
                rvalid = 1'b1;
                if (r_hs && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux looks at the address of the beat about to be presented.
    assign rd_off = ar_hs ? araddr[11:0] : addr_nxt[11:0];

    always_comb begin
        rd_word = '0;
        case (rd_off)
            OFF_SRC:    rd_word[DATA_W-1:0] = src_q;
            OFF_DST:    rd_word[DATA_W-1:0] = dst_q;
            OFF_QTY:    rd_word[DATA_W-1:0] = qty_q;
            OFF_CTRL:   rd_word = '0;
            OFF_STATUS: rd_word[1:0] = {done_q, busy_q};
            OFF_IE:     rd_word[0] = ie_q;
            default:    rd_word[DATA_W] = 1'b1;
        endcase
    end

    // NOTE: read data is captured when a beat is loaded, so it holds under
    // back-pressure even if STATUS changes while rready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs || ar_hs) begin
                id_q    <= aw_hs ? awid   : arid;
                addr_q  <= aw_hs ? awaddr : araddr;
                len_q   <= aw_hs ? awlen  : arlen;
                fixed_q <= ((aw_hs ? awburst : arburst) == BURST_FIXED);
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end
            if (ar_hs || (r_hs && !last_beat)) begin
                rdata_q <= rd_word[DATA_W-1:0];
                rresp_q <= rd_word[DATA_W] ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_hs || (r_hs && !last_beat)) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + LEN_W'(1);
            end
            if (w_hs && !w_mapped) err_q <= 1'b1;
        end
    end

    // Configuration is frozen while the engine runs; finish beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            qty_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ie_q     <= 1'b0;
            dma_en_q <= 1'b0;
        end else begin
            dma_en_q <= start;
            if (wr_cfg && (w_off == OFF_SRC)) src_q <= merge_bytes(src_q, wdata, wstrb);
            if (wr_cfg && (w_off == OFF_DST)) dst_q <= merge_bytes(dst_q, wdata, wstrb);
            if (wr_cfg && (w_off == OFF_QTY)) qty_q <= merge_bytes(qty_q, wdata, wstrb);
            if (start)          busy_q <= 1'b1;
            else if (dma_fin_i) busy_q <= 1'b0;
            if (dma_fin_i)     done_q <= 1'b1;
            else if (clr_done) done_q <= 1'b0;
            if (ie_wr) ie_q <= wdata[0];
        end
    end

    assign bid        = id_q;
    assign rid        = id_q;
    assign bresp      = ((state_q == BRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign rlast      = (state_q == RDATA) && last_beat;
    assign dma_en_o   = dma_en_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign data_qty_o = qty_q;
    assign irq_o      = done_q & ie_q;

endmodule
